// File: rtl/othello_pkg.sv
// Shared Othello definitions for the move datapath, validator and flip stage.
// Board RAM is a 10-wide walled layout: address = 11 + 10*row + col.
package othello_pkg;

   localparam int BOARD_W = 10;

   typedef enum logic [1:0] {
      CELL_NULL  = 2'b00,
      CELL_BLACK = 2'b01,
      CELL_WHITE = 2'b10,
      CELL_WALL  = 2'b11
   } cell_e;

   // Ray step per direction index d = 0..7 (NW, N, NE, W, E, SW, S, SE)
   localparam logic signed [7:0] DIR_OFF [8] = '{
      8'(-(BOARD_W + 1)), 8'(-BOARD_W), 8'(-(BOARD_W - 1)), -8'sd1,
      8'sd1, 8'(BOARD_W - 1), 8'(BOARD_W), 8'(BOARD_W + 1)
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TGT_EVAL,
      ST_DIR_ISSUE,
      ST_DIR_EVAL,
      ST_NEXT_DIR,
      ST_DONE
   } state_e;

   function automatic cell_e own_code(input logic player);
      return player ? CELL_WHITE : CELL_BLACK;
   endfunction

   function automatic cell_e opp_code(input logic player);
      return player ? CELL_BLACK : CELL_WHITE;
   endfunction

endpackage

// File: rtl/move_validator.sv
// Checks an Othello move by scanning all 8 rays through the board RAM read port.
// Reports a one-cycle valid/invalid pulse and a held per-direction bracket mask.
module move_validator
   import othello_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic              player,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [1:0]        rd_data,
   output logic              busy,
   output logic              mv_valid,
   output logic              mv_invalid,
   output logic [7:0]        dir_mask
);

   state_e            state_q;
   logic [ADDR_W-1:0] tgt_q;
   logic [ADDR_W-1:0] cur_q;
   logic              player_q;
   logic [2:0]        dir_q;
   logic [3:0]        n_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              busy_q;
   logic              mv_valid_q;
   logic              mv_invalid_q;
   logic [7:0]        dir_mask_q;

   logic [ADDR_W-1:0] off_w;
   logic [ADDR_W-1:0] step_d;
   cell_e             cell_w;

   // The first step of a ray starts from the target; later steps from the last cell read.
   assign off_w  = ADDR_W'(DIR_OFF[dir_q]);
   assign step_d = ((n_q == 4'd0) ? tgt_q : cur_q) + off_w;
   assign cell_w = cell_e'(rd_data);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         tgt_q        <= '0;
         cur_q        <= '0;
         player_q     <= 1'b0;
         dir_q        <= 3'd0;
         n_q          <= 4'd0;
         rd_addr_q    <= '0;
         busy_q       <= 1'b0;
         mv_valid_q   <= 1'b0;
         mv_invalid_q <= 1'b0;
         dir_mask_q   <= 8'd0;
      end else begin
         mv_valid_q   <= 1'b0;
         mv_invalid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  tgt_q      <= s_addr;
                  player_q   <= player;
                  rd_addr_q  <= s_addr;
                  dir_mask_q <= 8'd0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_TGT_EVAL;
               end
            end
            ST_TGT_EVAL: begin
               if (cell_w != CELL_NULL) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  dir_q   <= 3'd0;
                  n_q     <= 4'd0;
                  state_q <= ST_DIR_ISSUE;
               end
            end
            ST_DIR_ISSUE: begin
               cur_q     <= step_d;
               rd_addr_q <= step_d;
               n_q       <= n_q + 4'd1;
               state_q   <= ST_DIR_EVAL;
            end
            ST_DIR_EVAL: begin
               if (cell_w == opp_code(player_q)) begin
                  state_q <= ST_DIR_ISSUE;
               end else begin
                  // Own piece brackets only if at least one opponent lies between.
                  if (cell_w == own_code(player_q) && n_q >= 4'd2) begin
                     dir_mask_q[dir_q] <= 1'b1;
                  end
                  state_q <= ST_NEXT_DIR;
               end
            end
            ST_NEXT_DIR: begin
               if (dir_q == 3'd7) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  dir_q   <= dir_q + 3'd1;
                  n_q     <= 4'd0;
                  state_q <= ST_DIR_ISSUE;
               end
            end
            ST_DONE: begin
               mv_valid_q   <= |dir_mask_q;
               mv_invalid_q <= ~|dir_mask_q;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_addr    = rd_addr_q;
   assign busy       = busy_q;
   assign mv_valid   = mv_valid_q;
   assign mv_invalid = mv_invalid_q;
   assign dir_mask   = dir_mask_q;

endmodule

// File: tb/tb_move_validator.sv
// Bench for move_validator: board RAM model, ray-walking reference, per-cycle compare.
module tb_move_validator;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [6:0] s_addr;
   logic       player;
   logic [6:0] rd_addr;
   logic [1:0] rd_data;
   logic       busy;
   logic       mv_valid;
   logic       mv_invalid;
   logic [7:0] dir_mask;

   logic [1:0] mem [128];

   int vectors = 0;
   int errors  = 0;

   always #5 clock = ~clock;

   // Read data in the cycle after the address register is loaded.
   assign rd_data = mem[rd_addr];

   move_validator #(.ADDR_W(7)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .s_addr     (s_addr),
      .player     (player),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .mv_valid   (mv_valid),
      .mv_invalid (mv_invalid),
      .dir_mask   (dir_mask)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: walk each ray cell by cell; returns bracket mask and start-to-pulse latency.
   function automatic void model(input int s, input bit pl, output logic [7:0] m, output int lat);
      int offs [8];
      int own;
      int opp;
      offs = '{-11, -10, -9, -1, 1, 9, 10, 11};
      own  = pl ? 2 : 1;
      opp  = pl ? 1 : 2;
      m    = 8'd0;
      lat  = 3;
      if (mem[s] != 2'b00) return;
      for (int d = 0; d < 8; d++) begin
         int a;
         int n;
         bit go;
         a  = s;
         n  = 0;
         go = 1'b1;
         while (go) begin
            a = (a + offs[d] + 128) % 128;
            n++;
            if (int'(mem[a]) != opp) begin
               go = 1'b0;
               if (int'(mem[a]) == own && n >= 2) m[d] = 1'b1;
            end
         end
         lat += 2 * n + 1;
      end
   endfunction

   // Reference timeline: age counts cycles since acceptance (pulse at age == exp_lat).
   bit         chk_en    = 1'b0;
   bit         active    = 1'b0;
   bit         rd_zero   = 1'b1;
   int         age       = 0;
   int         exp_lat   = 0;
   logic [7:0] exp_mask  = 8'd0;
   logic [7:0] held_mask = 8'd0;
   logic [6:0] exp_tgt   = 7'd0;

   always @(posedge clock) begin
      bit ready;
      if (reset !== 1'b1) begin
         active    = 1'b0;
         held_mask = 8'd0;
         rd_zero   = 1'b1;
      end else begin
         ready = !active || age >= exp_lat;
         if (active) age++;
         if (active && age > exp_lat) begin
            active    = 1'b0;
            held_mask = exp_mask;
         end
         if (ready && start) begin
            model(int'(s_addr), player, exp_mask, exp_lat);
            exp_tgt = s_addr;
            active  = 1'b1;
            age     = 1;
            rd_zero = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("busy", busy, active && age <= exp_lat - 2);
         check("mv_valid", mv_valid, active && age == exp_lat && exp_mask != 0);
         check("mv_invalid", mv_invalid, active && age == exp_lat && exp_mask == 0);
         if (active && age < exp_lat) check("dir_mask_subset", dir_mask & ~exp_mask, 0);
         else check("dir_mask", dir_mask, active ? exp_mask : held_mask);
         if (rd_zero) check("rd_addr_reset", rd_addr, 0);
         else if (active && exp_lat == 3) check("rd_addr_target_only", rd_addr, exp_tgt);
      end
   end

   task automatic clear_board();
      for (int a = 0; a < 128; a++) begin
         int r;
         int c;
         r = a / 10;
         c = a % 10;
         mem[a] = (a < 100 && r >= 1 && r <= 8 && c >= 1 && c <= 8) ? 2'b00 : 2'b11;
      end
   endtask

   task automatic opening_board();
      clear_board();
      mem[44] = 2'b10;
      mem[55] = 2'b10;
      mem[45] = 2'b01;
      mem[54] = 2'b01;
   endtask

   task automatic random_board();
      clear_board();
      for (int a = 11; a <= 88; a++) begin
         if (mem[a] == 2'b00) begin
            int r;
            r = $urandom_range(0, 9);
            mem[a] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
         end
      end
   endtask

   // Start a check, optionally poking start while busy and in the DONE cycle; wait for the pulse.
   task automatic do_move(input int s, input bit pl, input bit inject, input bit poke,
                          output int lat, output bit valid, output logic [7:0] mask);
      int k;
      bit got;
      bit poked;
      got   = 1'b0;
      poked = 1'b0;
      lat   = -1;
      valid = 1'b0;
      mask  = 8'd0;
      @(negedge clock);
      s_addr = 7'(s);
      player = pl;
      start  = 1'b1;
      @(negedge clock);
      start  = inject;
      s_addr = 7'($urandom);
      player = 1'($urandom);
      k = 1;
      while (!got && k < 300) begin
         @(negedge clock);
         k++;
         start = 1'b0;
         if (mv_valid || mv_invalid) begin
            got   = 1'b1;
            lat   = k;
            valid = mv_valid;
            mask  = dir_mask;
         end else if (poke && !poked && !busy) begin
            start = 1'b1;
            poked = 1'b1;
         end
      end
      if (!got) begin
         vectors++;
         errors++;
         $display("FAIL pulse_timeout: got no pulse within %0d cycles, required one", k);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      bit         valid;
      logic [7:0] mask;
      logic [7:0] mm;
      int         ml;

      reset  = 1'b0;
      start  = 1'b0;
      s_addr = 7'd0;
      player = 1'b0;
      clear_board();
      repeat (3) @(negedge clock);
      chk_en = 1'b1;
      check("reset_busy", busy, 0);
      check("reset_dir_mask", dir_mask, 0);
      check("reset_rd_addr", rd_addr, 0);
      reset = 1'b1;

      // Opening position, black at 34: bracket south only.
      opening_board();
      model(34, 1'b0, mm, ml);
      check("model_mask_34", mm, 8'h40);
      check("model_lat_34", ml, 29);
      do_move(34, 1'b0, 1'b1, 1'b1, lat, valid, mask);
      check("open34_valid", valid, 1);
      check("open34_mask", mask, 8'b0100_0000);
      check("open34_lat", lat, 29);

      do_move(33, 1'b0, 1'b0, 1'b0, lat, valid, mask);
      check("open33_valid", valid, 0);
      check("open33_mask", mask, 0);
      check("open33_lat", lat, 31);

      do_move(44, 1'b0, 1'b0, 1'b1, lat, valid, mask);
      check("occupied_valid", valid, 0);
      check("occupied_lat", lat, 3);
      do_move(0, 1'b1, 1'b1, 1'b0, lat, valid, mask);
      check("wall_valid", valid, 0);
      check("wall_lat", lat, 3);

      clear_board();
      mem[44] = 2'b10;
      mem[45] = 2'b10;
      mem[53] = 2'b10;
      mem[46] = 2'b01;
      mem[63] = 2'b01;
      do_move(43, 1'b0, 1'b0, 1'b0, lat, valid, mask);
      check("two_dir_valid", valid, 1);
      check("two_dir_mask", mask, 8'b0101_0000);
      check("two_dir_lat", lat, 33);

      clear_board();
      mem[45] = 2'b01;
      do_move(44, 1'b0, 1'b0, 1'b0, lat, valid, mask);
      check("adjacent_valid", valid, 0);
      check("adjacent_mask", mask, 0);
      check("adjacent_lat", lat, 27);

      // Reset mid-scan with a stray start while busy; no pulse may follow.
      opening_board();
      @(negedge clock);
      s_addr = 7'd34;
      player = 1'b0;
      start  = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_dir_mask", dir_mask, 0);
      check("midrst_rd_addr", rd_addr, 0);
      repeat (40) @(negedge clock);
      do_move(34, 1'b0, 1'b0, 1'b0, lat, valid, mask);
      check("post_rst_mask", mask, 8'b0100_0000);
      check("post_rst_lat", lat, 29);

      // Random boards and targets; the per-cycle compare does the checking.
      for (int i = 0; i < 60; i++) begin
         int s;
         random_board();
         if ($urandom_range(0, 4) == 0) s = $urandom_range(0, 127);
         else s = 11 + 10 * $urandom_range(0, 7) + $urandom_range(0, 7);
         do_move(s, 1'($urandom), 1'($urandom), 1'($urandom), lat, valid, mask);
      end

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
